// File: rtl/display_mux_0_13.sv
//==============================================================================
// Module      : display_mux_0_13
// Description : Two-digit multiplexed 7-segment driver for a 0..13 count, with
//               wrap detection, lap counter and sticky out-of-range flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module display_mux_0_13 #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap_pulse,
    output logic [7:0] lap_count,
    output logic       range_err
);

    localparam logic [15:0] c_DIV_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  c_SEG_DASH = 7'h40;
    localparam logic [6:0]  c_SEG_OFF  = 7'h00;

    logic [3:0]  r_cnt;
    logic [3:0]  r_prev;
    logic [15:0] r_div;
    logic        r_sel;

    logic       w_tens;
    logic [3:0] w_units;
    logic       w_out_of_range;
    logic       w_wrap;
    logic [6:0] w_units_seg;
    logic [6:0] w_seg_next;

    assign w_tens         = (r_cnt >= 4'd10);
    assign w_units        = w_tens ? (r_cnt - 4'd10) : r_cnt;
    assign w_out_of_range = (r_cnt >= 4'd14);
    assign w_wrap         = (r_cnt == 4'd0) && (r_prev == 4'd13);

    always_comb begin
        w_units_seg = c_SEG_OFF;
        case (w_units)
            4'd0:    w_units_seg = 7'h3F;
            4'd1:    w_units_seg = 7'h06;
            4'd2:    w_units_seg = 7'h5B;
            4'd3:    w_units_seg = 7'h4F;
            4'd4:    w_units_seg = 7'h66;
            4'd5:    w_units_seg = 7'h6D;
            4'd6:    w_units_seg = 7'h7D;
            4'd7:    w_units_seg = 7'h07;
            4'd8:    w_units_seg = 7'h7F;
            4'd9:    w_units_seg = 7'h6F;
            default: w_units_seg = c_SEG_OFF;
        endcase
    end

    // Tens digit can only be 0 (blanked) or 1; dash overrides both slots.
    always_comb begin
        w_seg_next = c_SEG_OFF;
        if (w_out_of_range) begin
            w_seg_next = c_SEG_DASH;
        end else if (r_sel) begin
            w_seg_next = w_tens ? 7'h06 : c_SEG_OFF;
        end else begin
            w_seg_next = w_units_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_prev     <= 4'd0;
            r_div      <= 16'd0;
            r_sel      <= 1'b0;
            seg        <= c_SEG_OFF;
            an         <= 2'b00;
            wrap_pulse <= 1'b0;
            lap_count  <= 8'd0;
            range_err  <= 1'b0;
        end else begin
            r_cnt  <= count_in;
            r_prev <= r_cnt;
            if (r_div == c_DIV_LAST) begin
                r_div <= 16'd0;
                r_sel <= ~r_sel;
            end else begin
                r_div <= r_div + 16'd1;
            end
            seg        <= w_seg_next;
            an         <= r_sel ? 2'b10 : 2'b01;
            wrap_pulse <= w_wrap;
            if (w_wrap) begin
                lap_count <= lap_count + 8'd1;
            end
            if (w_out_of_range) begin
                range_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_mux_0_13.sv
//==============================================================================
// Module      : tb_display_mux_0_13
// Description : Scoreboard bench for display_mux_0_13 against a cycle-index
//               reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_display_mux_0_13;

    localparam int c_N = 4;
    localparam logic [6:0] c_SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       wrap;
        logic [7:0] lap;
        logic       rerr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap_pulse;
    logic [7:0] lap_count;
    logic       range_err;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Reference model state: edges since reset, held count, previous count.
    int         m_n;
    int         m_c1;
    int         m_c0;
    logic [7:0] m_laps;
    logic       m_rerr;
    logic [3:0] last_v;

    display_mux_0_13 #(.REFRESH_DIV(c_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .seg        (seg),
        .an         (an),
        .wrap_pulse (wrap_pulse),
        .lap_count  (lap_count),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model(input logic r, input logic [3:0] v);
        exp_t e;
        logic sel;
        int   tens;
        int   units;
        e = '0;
        if (r) begin
            m_n = 0; m_c1 = 0; m_c0 = 0; m_laps = 8'd0; m_rerr = 1'b0;
        end else begin
            sel   = ((m_n / c_N) % 2) == 1;
            tens  = (m_c1 >= 10) ? 1 : 0;
            units = m_c1 - 10 * tens;
            if (m_c1 >= 14)     e.seg = 7'h40;
            else if (sel)       e.seg = (tens == 1) ? c_SEG[1] : 7'h00;
            else                e.seg = c_SEG[units];
            e.an   = sel ? 2'b10 : 2'b01;
            e.wrap = (m_c1 == 0) && (m_c0 == 13);
            if (e.wrap) m_laps = m_laps + 8'd1;
            if (m_c1 >= 14) m_rerr = 1'b1;
            e.lap  = m_laps;
            e.rerr = m_rerr;
            m_c0 = m_c1;
            m_c1 = int'(v);
            m_n++;
        end
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [3:0] v);
        rst      = r;
        count_in = v;
        last_v   = v;
        @(posedge clk);
        #1;
        model(r, v);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seg", int'(seg), int'(e.seg));
            chk("an", int'(an), int'(e.an));
            chk("wrap_pulse", int'(wrap_pulse), int'(e.wrap));
            chk("lap_count", int'(lap_count), int'(e.lap));
            chk("range_err", int'(range_err), int'(e.rerr));
            checks++;
            if (an == 2'b11) begin
                errors++;
                $display("FAIL an_onehot: got %b expected not 11", an);
            end
        end
    end

    initial begin
        rst = 1'b1; count_in = 4'd0; last_v = 4'd0;
        m_n = 0; m_c1 = 0; m_c0 = 0; m_laps = 8'd0; m_rerr = 1'b0;
        repeat (3) cyc(1'b1, 4'd0);
        // Held counts: single digit with blanked tens, then two digits.
        repeat (20) cyc(1'b0, 4'd7);
        repeat (20) cyc(1'b0, 4'd12);
        // Stepped 0..13,0 three times, ten cycles per value.
        cyc(1'b1, 4'd0);
        for (int rep = 0; rep < 3; rep++)
            for (int v = 0; v <= 13; v++)
                repeat (10) cyc(1'b0, 4'(v));
        repeat (10) cyc(1'b0, 4'd0);
        // One out-of-range cycle then back in range.
        cyc(1'b0, 4'd14);
        repeat (12) cyc(1'b0, 4'd5);
        // Reset lands exactly where a wrap pulse would be registered.
        cyc(1'b1, 4'd0);
        repeat (2) cyc(1'b0, 4'd13);
        cyc(1'b0, 4'd0);
        cyc(1'b1, 4'd0);
        repeat (6) cyc(1'b0, 4'd0);
        // 256 forced wraps bring lap_count back to zero.
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 4'd13);
            cyc(1'b0, 4'd0);
        end
        repeat (4) cyc(1'b0, 4'd0);
        // Randomized mix of counting runs, random values and rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [3:0] v;
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) != 0)
                v = (last_v >= 4'd13) ? 4'd0 : last_v + 4'd1;
            else if ($urandom_range(0, 7) == 0)
                v = 4'($urandom_range(14, 15));
            else
                v = 4'($urandom_range(0, 13));
            cyc(r, v);
        end
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
